// File: rtl/baud_config_ctrl.sv
// Baud configuration controller: maps a baud code to the sample-enable divisor,
// applies changes only while the link is idle, and derives a per-bit tick.
module baud_config_ctrl #(
  parameter int          OVERSAMPLE  = 16,
  parameter logic [2:0]  DEFAULT_SEL = 3'b111,
  parameter int          TIMEOUT     = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  baud_select,
  input  logic        cfg_req,
  input  logic        link_busy,
  input  logic        sample_enable,
  output logic [15:0] max_value,
  output logic        gen_restart,
  output logic        bit_tick,
  output logic        cfg_busy,
  output logic        cfg_ack,
  output logic        cfg_err,
  output logic [2:0]  active_sel
);

  localparam int OSW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_IDLE, APPLY, DONE} state_t;

  state_t          state_reg, state_next;
  logic [2:0]      pending_sel_reg;
  logic [TW-1:0]   timeout_reg;
  logic            abort_reg;
  logic [OSW-1:0]  os_count_reg;
  logic [15:0]     max_value_reg;
  logic [2:0]      active_sel_reg;
  logic            gen_restart_reg;
  logic            bit_tick_reg;
  logic            cfg_busy_reg;
  logic            cfg_ack_reg;
  logic            cfg_err_reg;

  function automatic logic [15:0] divisor(input logic [2:0] code);
    case (code)
      3'd0:    divisor = 16'd20832;
      3'd1:    divisor = 16'd5207;
      3'd2:    divisor = 16'd1301;
      3'd3:    divisor = 16'd650;
      3'd4:    divisor = 16'd325;
      3'd5:    divisor = 16'd162;
      3'd6:    divisor = 16'd108;
      default: divisor = 16'd53;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (cfg_req)
          state_next = (baud_select == active_sel_reg) ? DONE : WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (!link_busy)
          state_next = APPLY;
        else if (timeout_reg == TW'(TIMEOUT - 1))
          state_next = DONE;
      end
      APPLY:   state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_sel_reg <= DEFAULT_SEL;
      timeout_reg     <= '0;
      abort_reg       <= 1'b0;
      os_count_reg    <= '0;
      max_value_reg   <= divisor(DEFAULT_SEL);
      active_sel_reg  <= DEFAULT_SEL;
      gen_restart_reg <= 1'b0;
      bit_tick_reg    <= 1'b0;
      cfg_busy_reg    <= 1'b0;
      cfg_ack_reg     <= 1'b0;
      cfg_err_reg     <= 1'b0;
    end else begin
      gen_restart_reg <= 1'b0;
      bit_tick_reg    <= 1'b0;
      cfg_ack_reg     <= 1'b0;
      cfg_err_reg     <= 1'b0;
      cfg_busy_reg    <= (state_next != IDLE);

      case (state_reg)
        IDLE: begin
          if (cfg_req) begin
            pending_sel_reg <= baud_select;
            timeout_reg     <= '0;
            abort_reg       <= 1'b0;
          end
        end
        WAIT_IDLE: begin
          if (link_busy) begin
            if (timeout_reg == TW'(TIMEOUT - 1)) abort_reg <= 1'b1;
            else                                 timeout_reg <= timeout_reg + 1'b1;
          end
        end
        APPLY: begin
          max_value_reg   <= divisor(pending_sel_reg);
          active_sel_reg  <= pending_sel_reg;
          gen_restart_reg <= 1'b1;
        end
        default: begin
          cfg_ack_reg <= 1'b1;
          cfg_err_reg <= abort_reg;
        end
      endcase

      // The restart clear wins; pulses in the restart cycle belong to the old rate.
      if (state_reg == APPLY) begin
        os_count_reg <= '0;
      end else if (sample_enable && !gen_restart_reg) begin
        if (os_count_reg == OSW'(OVERSAMPLE - 1)) begin
          os_count_reg <= '0;
          bit_tick_reg <= 1'b1;
        end else begin
          os_count_reg <= os_count_reg + 1'b1;
        end
      end
    end
  end

  assign max_value   = max_value_reg;
  assign active_sel  = active_sel_reg;
  assign gen_restart = gen_restart_reg;
  assign bit_tick    = bit_tick_reg;
  assign cfg_busy    = cfg_busy_reg;
  assign cfg_ack     = cfg_ack_reg;
  assign cfg_err     = cfg_err_reg;

endmodule

// File: tb/tb_baud_config_ctrl.sv
// Self-checking bench for baud_config_ctrl against a pulse-count/table reference model.
module tb_baud_config_ctrl;

  localparam int OS = 16;
  localparam int TO = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  baud_select;
  logic        cfg_req;
  logic        link_busy;
  logic        sample_enable;
  logic [15:0] max_value;
  logic        gen_restart;
  logic        bit_tick;
  logic        cfg_busy;
  logic        cfg_ack;
  logic        cfg_err;
  logic [2:0]  active_sel;

  int checks = 0;
  int failures = 0;

  // reference model: applied code and sample pulses seen since the last restart
  int model_sel;
  int pulses;
  int div_table [8] = '{20832, 5207, 1301, 650, 325, 162, 108, 53};

  always #5 clk = ~clk;

  baud_config_ctrl #(.OVERSAMPLE(OS), .DEFAULT_SEL(3'b111), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .baud_select(baud_select), .cfg_req(cfg_req),
    .link_busy(link_busy), .sample_enable(sample_enable), .max_value(max_value),
    .gen_restart(gen_restart), .bit_tick(bit_tick), .cfg_busy(cfg_busy),
    .cfg_ack(cfg_ack), .cfg_err(cfg_err), .active_sel(active_sel)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_se(input logic se, output logic tick);
    sample_enable = se;
    step();
    tick = bit_tick;
    sample_enable = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cfg_req = 1'b0; link_busy = 1'b0; sample_enable = 1'b0; baud_select = 3'd0;
    repeat (3) step();
    reset = 1'b0;
    step();
    model_sel = 7; pulses = 0;
    checks++;
    if (max_value !== 16'd53 || active_sel !== 3'd7) begin
      failures++; $display("FAIL reset_cfg: max_value=%0d active_sel=%0d, required 53/7", max_value, active_sel);
    end
    checks++;
    if ({gen_restart, bit_tick, cfg_ack, cfg_err, cfg_busy} !== 5'b0) begin
      failures++; $display("FAIL reset_pulses: restart/tick/ack/err/busy=%b, required 00000",
                           {gen_restart, bit_tick, cfg_ack, cfg_err, cfg_busy});
    end
    $display("reset: max_value=%0d active_sel=%0d", max_value, active_sel);
  endtask

  task automatic test_bit_tick(input int ncyc, input bit random_se);
    logic se, tick, exp;
    int ticks_seen = 0, ticks_exp = 0;
    for (int i = 0; i < ncyc; i++) begin
      se = random_se ? logic'($urandom_range(0, 1)) : 1'b1;
      exp = se && ((pulses + 1) % OS == 0);
      if (se) pulses++;
      drive_se(se, tick);
      if (tick) ticks_seen++;
      if (exp) ticks_exp++;
      checks++;
      if (tick !== exp) begin
        failures++; $display("FAIL bit_tick: cycle %0d pulses=%0d got %b, required %b", i, pulses, tick, exp);
      end
    end
    $display("bit_tick: %0d cycles, %0d ticks (expected %0d)", ncyc, ticks_seen, ticks_exp);
  endtask

  task automatic test_apply();
    int code, old_max;
    do code = $urandom_range(1, 7); while (code == model_sel);
    old_max = div_table[model_sel];
    baud_select = 3'(code); cfg_req = 1'b1; link_busy = 1'b0;
    step();  // E0
    cfg_req = 1'b0;
    checks++;
    if (cfg_busy !== 1'b1 || gen_restart !== 1'b0) begin
      failures++; $display("FAIL apply_e0: busy=%b restart=%b, required 1/0", cfg_busy, gen_restart);
    end
    step();  // E1
    checks++;
    if (max_value !== 16'(old_max) || gen_restart !== 1'b0) begin
      failures++; $display("FAIL apply_e1: max_value=%0d restart=%b, required %0d/0", max_value, gen_restart, old_max);
    end
    step();  // E2
    checks++;
    if (max_value !== 16'(div_table[code]) || gen_restart !== 1'b1 || active_sel !== 3'(code) || cfg_ack !== 1'b0) begin
      failures++; $display("FAIL apply_e2: max_value=%0d restart=%b sel=%0d ack=%b, required %0d/1/%0d/0",
                           max_value, gen_restart, active_sel, cfg_ack, div_table[code], code);
    end
    step();  // E3
    checks++;
    if (cfg_ack !== 1'b1 || cfg_err !== 1'b0 || gen_restart !== 1'b0) begin
      failures++; $display("FAIL apply_ack: ack=%b err=%b restart=%b, required 1/0/0", cfg_ack, cfg_err, gen_restart);
    end
    step();  // E4
    checks++;
    if (cfg_ack !== 1'b0 || cfg_busy !== 1'b0) begin
      failures++; $display("FAIL apply_end: ack=%b busy=%b, required 0/0", cfg_ack, cfg_busy);
    end
    model_sel = code; pulses = 0;
    $display("apply: code=%0d max_value=%0d", code, max_value);
  endtask

  task automatic test_wait_busy();
    int old_max = div_table[model_sel];
    bit bad = 0;
    baud_select = 3'd0; cfg_req = 1'b1; link_busy = 1'b1;
    step();
    cfg_req = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (cfg_busy !== 1'b1 || max_value !== 16'(old_max) || gen_restart !== 1'b0) bad = 1;
      step();
    end
    checks++;
    if (bad) begin
      failures++; $display("FAIL wait_hold: busy=%b max_value=%0d while link busy, required 1/%0d", cfg_busy, max_value, old_max);
    end
    link_busy = 1'b0;
    step();
    checks++;
    if (max_value !== 16'(old_max)) begin
      failures++; $display("FAIL wait_e1: max_value=%0d, required %0d", max_value, old_max);
    end
    step();
    checks++;
    if (max_value !== 16'd20832 || gen_restart !== 1'b1 || active_sel !== 3'd0) begin
      failures++; $display("FAIL wait_apply: max_value=%0d restart=%b sel=%0d, required 20832/1/0", max_value, gen_restart, active_sel);
    end
    step();
    checks++;
    if (cfg_ack !== 1'b1 || cfg_err !== 1'b0) begin
      failures++; $display("FAIL wait_ack: ack=%b err=%b, required 1/0", cfg_ack, cfg_err);
    end
    step();
    model_sel = 0; pulses = 0;
    $display("wait_busy: max_value=%0d active_sel=%0d", max_value, active_sel);
  endtask

  task automatic test_timeout();
    int code, n_ack = -1;
    bit bad = 0;
    code = (model_sel + 1) % 8;
    test_bit_tick(5, 0);
    baud_select = 3'(code); cfg_req = 1'b1; link_busy = 1'b1;
    step();
    cfg_req = 1'b0;
    for (int n = 1; n <= TO + 20; n++) begin
      step();
      if (gen_restart !== 1'b0 || max_value !== 16'(div_table[model_sel])) bad = 1;
      if (cfg_ack === 1'b1) begin
        n_ack = n;
        checks++;
        if (cfg_err !== 1'b1) begin
          failures++; $display("FAIL timeout_err: err=%b, required 1", cfg_err);
        end
        break;
      end
    end
    checks++;
    if (n_ack != TO + 1) begin
      failures++; $display("FAIL timeout_latency: ack after %0d edges, required %0d (-1 = none)", n_ack, TO + 1);
    end
    checks++;
    if (bad || active_sel !== 3'(model_sel)) begin
      failures++; $display("FAIL timeout_nochange: sel=%0d max_value=%0d, required %0d/%0d no restart",
                           active_sel, max_value, model_sel, div_table[model_sel]);
    end
    link_busy = 1'b0;
    step();
    $display("timeout: ack after %0d edges err=%b", n_ack, cfg_err);
    test_bit_tick(OS + 3, 0);
  endtask

  task automatic test_same_code();
    logic tick, exp;
    int acks = 0;
    for (int c = 0; c < 8; c++) begin
      if (c == 0) begin baud_select = 3'(model_sel); cfg_req = 1'b1; end
      else if (c == 1) begin baud_select = 3'((model_sel + 3) % 8); cfg_req = 1'b1; end
      else cfg_req = 1'b0;
      exp = ((pulses + 1) % OS == 0);
      pulses++;
      drive_se(1'b1, tick);
      if (cfg_ack === 1'b1) acks++;
      checks++;
      if (tick !== exp || gen_restart !== 1'b0) begin
        failures++; $display("FAIL same_cadence: cycle %0d tick=%b restart=%b, required %b/0", c, tick, gen_restart, exp);
      end
      if (c == 1) begin
        checks++;
        if (cfg_ack !== 1'b1 || cfg_err !== 1'b0) begin
          failures++; $display("FAIL same_ack: ack=%b err=%b, required 1/0", cfg_ack, cfg_err);
        end
      end
    end
    cfg_req = 1'b0;
    checks++;
    if (acks != 1 || active_sel !== 3'(model_sel) || max_value !== 16'(div_table[model_sel])) begin
      failures++; $display("FAIL same_once: acks=%0d sel=%0d max_value=%0d, required 1/%0d/%0d",
                           acks, active_sel, max_value, model_sel, div_table[model_sel]);
    end
    $display("same_code: code=%0d acks=%0d", model_sel, acks);
  endtask

  task automatic test_reset_mid();
    bit bad = 0;
    baud_select = 3'((model_sel + 2) % 8);
    if (baud_select == 3'd7) baud_select = 3'd1;
    cfg_req = 1'b1; link_busy = 1'b1;
    step();
    cfg_req = 1'b0;
    repeat (4) step();
    reset = 1'b1;
    #1;
    checks++;
    if (max_value !== 16'd53 || active_sel !== 3'd7 || cfg_busy !== 1'b0) begin
      failures++; $display("FAIL reset_async: max_value=%0d sel=%0d busy=%b, required 53/7/0", max_value, active_sel, cfg_busy);
    end
    step();
    reset = 1'b0; link_busy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (cfg_ack !== 1'b0 || gen_restart !== 1'b0 || cfg_busy !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      failures++; $display("FAIL reset_noack: ack/restart/busy seen after reset, required none");
    end
    model_sel = 7; pulses = 0;
    $display("reset_mid: max_value=%0d active_sel=%0d", max_value, active_sel);
  endtask

  initial begin
    test_reset();
    test_bit_tick(48, 1);
    test_apply();
    test_bit_tick(40, 1);
    test_wait_busy();
    test_bit_tick(20, 1);
    test_timeout();
    test_same_code();
    for (int k = 0; k < 3; k++) test_apply();
    test_reset_mid();
    test_bit_tick(24, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/baud_config_ctrl.md
Name: baud_config_ctrl

Overview:
- Configuration and sequencing controller for the UART sample-enable generator (16-bit divisor counter with `max_value` input, `sample_ENABLE` output, 100 MHz clk).
- Maps a 3-bit baud selection to the generator divisor and applies reconfiguration only while the link is idle.
- Restarts the generator on every change and derives a per-bit tick from the oversampled enable for TX/RX controllers.

Parameters:
- OVERSAMPLE, 16: sample_enable pulses per bit period; range 2..256.
- DEFAULT_SEL, 3'b111: baud selection applied at reset.
- TIMEOUT, 1024: maximum cycles spent waiting for link idle before abort; ≥2.

Ports:
- clk  input  1  system clock, 100 MHz
- reset  input  1  asynchronous, active-high reset
- baud_select  input  3  requested baud code, sampled with cfg_req
- cfg_req  input  1  one-cycle request to apply baud_select
- link_busy  input  1  high while TX or RX is mid-frame
- sample_enable  input  1  pulse from the generator
- max_value  output  16  divisor to the generator, registered
- gen_restart  output  1  one-cycle pulse to the generator, which clears its count
- bit_tick  output  1  one-cycle pulse every OVERSAMPLE sample_enable pulses
- cfg_busy  output  1  high whenever the state is not IDLE
- cfg_ack  output  1  one-cycle pulse when a request completes
- cfg_err  output  1  valid with cfg_ack; 1 means the request timed out and no change was made
- active_sel  output  3  currently applied baud code

Behaviour:
- Divisor table (code -> max_value): 000->20832 (300), 001->5207 (1200), 010->1301 (4800), 011->650 (9600), 100->325 (19200), 101->162 (38400), 110->108 (57600), 111->53 (115200).
- Reset (asynchronous) sets:
  - state=IDLE
  - max_value=table[DEFAULT_SEL], active_sel=DEFAULT_SEL
  - gen_restart=0, bit_tick=0, cfg_ack=0, cfg_err=0
  - os_count=0, timeout counter=0
- States: IDLE, WAIT_IDLE, APPLY, DONE. All outputs are registered.
- IDLE:
  - On cfg_req=1, latch pending_sel=baud_select and clear the timeout counter.
  - If pending_sel==active_sel, go to DONE (no restart). Otherwise go to WAIT_IDLE.
- WAIT_IDLE:
  - If link_busy=0, go to APPLY.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT-1 with link_busy still 1, set the abort flag and go to DONE.
- APPLY (one cycle):
  - max_value<=table[pending_sel], active_sel<=pending_sel, gen_restart<=1.
  - Clear os_count and go to DONE.
- DONE (one cycle): gen_restart<=0, cfg_ack<=1, cfg_err<=abort flag; go to IDLE. cfg_ack and cfg_err return to 0 on the next edge.
- Latency with link_busy=0 and a new code:
  - cfg_req sampled at edge E0.
  - max_value updates and gen_restart rises at E2.
  - cfg_ack is high from E3 to E4.
  - A same-code request acks at E1 to E2.
- cfg_req is ignored while cfg_busy=1; there is no queuing.
- link_busy rising during APPLY or DONE has no effect; the change is already committed.
- On abort, max_value and active_sel are unchanged, no gen_restart is issued, and os_count is untouched.
- bit_tick:
  - os_count counts sample_enable pulses 0..OVERSAMPLE-1 and wraps to 0.
  - bit_tick<=1 for one cycle on the edge where sample_enable=1 and os_count==OVERSAMPLE-1.
  - sample_enable is ignored in the APPLY cycle and while gen_restart=1. The os_count clear has priority.
- Reset asserted mid-operation returns to the reset values immediately. Any pending request is discarded with no ack.

Test Plan:
- Reset release -> max_value=53, active_sel=7, all pulses 0; 16 sample_enable pulses -> exactly one bit_tick, coincident with the edge after the 16th pulse.
- cfg_req with baud_select=3 and link_busy=0 -> max_value=650 and gen_restart high exactly 2 cycles after the request edge; cfg_ack=1 with cfg_err=0 one cycle later; active_sel=3.
- link_busy held high for 50 cycles, then low, with a request for code 0 -> cfg_busy high throughout, max_value stays at its old value until 2 cycles after link_busy falls, then becomes 20832.
- link_busy held high forever with TIMEOUT=1024 -> cfg_ack with cfg_err=1 after 1024 waiting cycles; max_value, active_sel and os_count unchanged; no gen_restart.
- Request for the current code (7) -> cfg_ack the following cycle with cfg_err=0, no gen_restart, and the bit_tick cadence undisturbed; a second cfg_req while cfg_busy=1 is ignored (one ack only).
- Reset asserted in WAIT_IDLE -> state IDLE, max_value=53, no cfg_ack emitted after reset releases.
